// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU arbiter: opcode encodings,
// status-bit positions and the opcode legality test.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SL  = 4'd6,
        ALU_SR  = 4'd7
    } aluop_t;

    // Bit positions inside the 3-bit {N, V, Z} status vector.
    localparam int STAT_Z = 0;
    localparam int STAT_V = 1;
    localparam int STAT_N = 2;

    // Only the lower half of the 4-bit opcode space is implemented by the ALU.
    function automatic logic op_legal(input logic [3:0] op);
        return !op[3];
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 32
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][3:0]    req_op;
    logic [NREQ-1:0][W-1:0]  req_a;
    logic [NREQ-1:0][W-1:0]  req_b;

    logic [NREQ-1:0]         rsp_valid;
    logic [NREQ-1:0]         rsp_ready;
    logic [W-1:0]            rsp_out;
    logic [2:0]              rsp_status;
    logic                    rsp_err;

    logic [3:0]              alu_op;
    logic [W-1:0]            alu_a;
    logic [W-1:0]            alu_b;
    logic [W-1:0]            alu_out;
    logic [2:0]              alu_status;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_status,
        output req_ready, rsp_valid, rsp_out, rsp_status, rsp_err, alu_op, alu_a, alu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_status,
        input  req_ready, rsp_valid, rsp_out, rsp_status, rsp_err, alu_op, alu_a, alu_b
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// in circular order. Grants only while en is high; ptr moves only on a grant.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan ptr+1, ptr+2, ... and grant the first active request.
    always_comb begin : pick
        int            idx;
        logic [IW-1:0] idx_w;
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        idx   = 0;
        idx_w = '0;
        gnt   = '0;
        ptr_d = ptr_q;
        if (en) begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                idx_w = IW'(idx);
                if (req[idx_w] && gnt == '0) begin
                    gnt[idx_w] = 1'b1;
                    ptr_d      = idx_w;
                end
            end
        end
    end

    // Last-winner register; reset points at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) ptr_q <= IW'(NREQ - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters.
// S1 registers the granted request and drives the ALU; S2 registers the
// ALU result and presents it to the issuing requester.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    import alu_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            adv1, adv2, arb_en;
    logic [NREQ-1:0] gnt;

    logic            valid1_q, valid1_d;
    logic [IW-1:0]   src1_q, src1_d;
    logic [3:0]      op1_q, op1_d;
    logic [W-1:0]    a1_q, a1_d;
    logic [W-1:0]    b1_q, b1_d;
    logic            err1_q, err1_d;

    logic            valid2_q, valid2_d;
    logic [IW-1:0]   src2_q, src2_d;
    logic [W-1:0]    out2_q, out2_d;
    logic [2:0]      status2_q, status2_d;
    logic            err2_q, err2_d;

    // Stage advance conditions; arbitration is also held off during reset.
    always_comb begin
        adv2   = !valid2_q || bus.rsp_ready[src2_q];
        adv1   = !valid1_q || adv2;
        arb_en = adv1 && rst_n;
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.req_valid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign bus.req_ready = gnt;

    // S1 next state: capture the winning request; illegal ops reach the ALU as ADD.
    always_comb begin
        valid1_d = valid1_q;
        src1_d   = src1_q;
        op1_d    = op1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        err1_d   = err1_q;
        if (adv1) begin
            valid1_d = |gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    src1_d = IW'(i);
                    op1_d  = op_legal(bus.req_op[i]) ? bus.req_op[i] : ALU_ADD;
                    a1_d   = bus.req_a[i];
                    b1_d   = bus.req_b[i];
                    err1_d = !op_legal(bus.req_op[i]);
                end
            end
        end
    end

    // S2 next state: take the ALU result, or zeros with err for an illegal op.
    always_comb begin
        valid2_d  = valid2_q;
        src2_d    = src2_q;
        out2_d    = out2_q;
        status2_d = status2_q;
        err2_d    = err2_q;
        if (adv2) begin
            valid2_d = valid1_q;
            if (valid1_q) begin
                src2_d    = src1_q;
                err2_d    = err1_q;
                out2_d    = err1_q ? '0 : bus.alu_out;
                status2_d = err1_q ? '0 : bus.alu_status;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q  <= 1'b0;
            src1_q    <= '0;
            op1_q     <= '0;
            a1_q      <= '0;
            b1_q      <= '0;
            err1_q    <= 1'b0;
            valid2_q  <= 1'b0;
            src2_q    <= '0;
            out2_q    <= '0;
            status2_q <= '0;
            err2_q    <= 1'b0;
        end else begin
            valid1_q  <= valid1_d;
            src1_q    <= src1_d;
            op1_q     <= op1_d;
            a1_q      <= a1_d;
            b1_q      <= b1_d;
            err1_q    <= err1_d;
            valid2_q  <= valid2_d;
            src2_q    <= src2_d;
            out2_q    <= out2_d;
            status2_q <= status2_d;
            err2_q    <= err2_d;
        end
    end

    // Response valid is the one-hot decode of the S2 source.
    always_comb begin
        bus.rsp_valid = '0;
        if (valid2_q) bus.rsp_valid[src2_q] = 1'b1;
    end

    assign bus.rsp_out    = out2_q;
    assign bus.rsp_status = status2_q;
    assign bus.rsp_err    = err2_q;
    assign bus.alu_op     = op1_q;
    assign bus.alu_a      = a1_q;
    assign bus.alu_b      = b1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: provides a behavioural ALU, drives directed and
// random traffic, and checks grants and responses against an in-order
// transaction model (a queue of accepted operations with their expected results).
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;

    typedef struct packed {
        logic [W-1:0] out;
        logic [2:0]   st;
    } alu_res_t;

    typedef struct {
        int           src;
        logic [W-1:0] out;
        logic [2:0]   st;
        logic         err;
        int           k;     // clock edge at which the request was accepted
    } item_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    bit   alu_op_bad;

    item_t           q[$];
    item_t           it;
    int              last_g;
    int              win;
    bit              head_out, drain, can_acc;
    logic [NREQ-1:0] exp_rv, exp_gnt, acc_mask;
    alu_res_t        r;

    alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU as specified: status {N, V, Z}, V from the a-b overflow detector.
    function automatic alu_res_t alu_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_res_t     res;
        logic [W-1:0] d;
        d = a - b;
        case (op)
            4'd0:    res.out = a + b;
            4'd1:    res.out = d;
            4'd2:    res.out = a & b;
            4'd3:    res.out = a | b;
            4'd4:    res.out = ~a;
            4'd5:    res.out = a ^ b;
            4'd6:    res.out = a << 1;
            4'd7:    res.out = a >> 1;
            default: res.out = '0;
        endcase
        res.st         = '0;
        res.st[STAT_Z] = (res.out == '0);
        res.st[STAT_N] = res.out[W-1];
        res.st[STAT_V] = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return res;
    endfunction

    always_comb begin
        {bus.alu_out, bus.alu_status} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.alu_op[3]) alu_op_bad = 1'b1;
        if (!rst_n) begin
            check("reset_req_ready", 64'(bus.req_ready), 64'd0);
            check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("reset_rsp_out", 64'(bus.rsp_out), 64'd0);
            check("reset_rsp_status", 64'(bus.rsp_status), 64'd0);
            check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
            check("reset_alu_op", 64'(bus.alu_op), 64'd0);
            check("reset_alu_a", 64'(bus.alu_a), 64'd0);
            check("reset_alu_b", 64'(bus.alu_b), 64'd0);
            q.delete();
            last_g   = NREQ - 1;
            acc_mask = '0;
        end else begin
            // The oldest operation is visible one edge after its acceptance edge.
            exp_rv   = '0;
            head_out = (q.size() > 0) && (cyc >= q[0].k + 1);
            if (head_out) exp_rv[q[0].src] = 1'b1;
            check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));

            drain   = head_out && bus.rsp_ready[q[0].src];
            // Two operations fit in flight; a third enters only if the oldest leaves.
            can_acc = (q.size() < 2) || drain;

            if (drain) begin
                check("rsp_out", 64'(bus.rsp_out), 64'(q[0].out));
                check("rsp_status", 64'(bus.rsp_status), 64'(q[0].st));
                check("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
                void'(q.pop_front());
            end

            win = -1;
            if (can_acc) begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (win < 0 && bus.req_valid[(last_g + i) % NREQ]) win = (last_g + i) % NREQ;
                end
            end
            exp_gnt = '0;
            if (win >= 0) exp_gnt[win] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
            acc_mask = bus.req_valid & bus.req_ready;

            if (win >= 0) begin
                it.src = win;
                it.k   = cyc + 1;
                if (bus.req_op[win][3]) begin
                    it.out = '0;
                    it.st  = '0;
                    it.err = 1'b1;
                end else begin
                    r      = alu_model(bus.req_op[win], bus.req_a[win], bus.req_b[win]);
                    it.out = r.out;
                    it.st  = r.st;
                    it.err = 1'b0;
                end
                q.push_back(it);
                last_g = win;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input int i);
        bus.req_op[i] = 4'($urandom_range(0, 9));
        bus.req_a[i]  = $urandom;
        bus.req_b[i]  = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        cyc           = 0;
        alu_op_bad    = 1'b0;
        last_g        = NREQ - 1;
        acc_mask      = '0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Contention: both requesters hold SUB 5-5 for four cycles.
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[i] = 4'd1;
            bus.req_a[i]  = 32'd5;
            bus.req_b[i]  = 32'd5;
        end
        bus.req_valid = 2'b11;
        repeat (4) tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // Single ADD crossing into the sign bit.
        bus.req_op[0] = 4'd0;
        bus.req_a[0]  = 32'h7FFF_FFFF;
        bus.req_b[0]  = 32'd1;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // Back-pressure on requester 0 while it streams.
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        rand_req(0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) bus.rsp_ready = '1;
            tick();
            if (acc_mask[0]) rand_req(0);
        end
        bus.req_valid = '0;
        repeat (3) tick();

        // Illegal opcode.
        bus.req_op[0] = 4'b1010;
        bus.req_a[0]  = $urandom;
        bus.req_b[0]  = $urandom;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // Reset with both stages full and responses blocked.
        bus.rsp_ready = '0;
        bus.req_valid = 2'b01;
        rand_req(0);
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        bus.rsp_ready = '1;
        bus.req_valid = 2'b11;
        rand_req(0);
        rand_req(1);
        rst_n = 1'b1;
        repeat (3) tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // Fairness: requester 1 always valid, requester 0 every other cycle.
        for (int i = 0; i < 20; i++) begin
            bus.req_valid[1] = 1'b1;
            bus.req_valid[0] = (i % 2 == 0);
            rand_req(0);
            rand_req(1);
            tick();
        end
        bus.req_valid = '0;
        repeat (3) tick();

        // Random traffic with random back-pressure; requests hold until accepted.
        for (int c = 0; c < 400; c++) begin
            bus.rsp_ready = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || acc_mask[i]) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    rand_req(i);
                end
            end
            tick();
        end

        // Drain.
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (6) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
        check("alu_op_legal", 64'(alu_op_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
